// File: rtl/io_port_unit.sv
// rtl/io_port_unit.sv - device I/O stage: input FIFO, held output port, interrupt synchroniser
//
// Purpose:
//   Buffers device words in a small FIFO that feeds the core's inputPort.
//   Holds the last word the core wrote in outputPort, with a valid/ready handshake.
//   Turns an asynchronous irq_req into a pending interrupt level that is cleared by int_ack.
//
// Ports:
//   clk, rst (async, active-low)
//   dev_in_data/dev_in_valid/dev_in_ready    device -> FIFO push side
//   inputPort/in_empty/in_count/port_rd      FIFO head, status and pop strobe for the core
//   port_wr/port_wdata                       core OUT write
//   outputPort/dev_out_valid/dev_out_ready   held word -> device handshake
//   out_overrun/ovf_clr                      sticky overwrite flag and its clear
//   irq_req/interrupt/int_ack                external request, pending level, acknowledge
module io_port_unit #(
  parameter int DATA_W   = 16,
  parameter int IN_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_W-1:0]           dev_in_data,
  input  logic                        dev_in_valid,
  output logic                        dev_in_ready,
  output logic [DATA_W-1:0]           inputPort,
  output logic                        in_empty,
  output logic [$clog2(IN_DEPTH):0]   in_count,
  input  logic                        port_rd,
  input  logic                        port_wr,
  input  logic [DATA_W-1:0]           port_wdata,
  output logic [DATA_W-1:0]           outputPort,
  output logic                        dev_out_valid,
  input  logic                        dev_out_ready,
  output logic                        out_overrun,
  input  logic                        ovf_clr,
  input  logic                        irq_req,
  output logic                        interrupt,
  input  logic                        int_ack
);

  localparam int AW = $clog2(IN_DEPTH);

  // Input FIFO
  logic [DATA_W-1:0] r_mem [IN_DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;

  // Pointers carry one extra wrap bit: equal means empty, differing only in
  // the wrap bit means full.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // Ready depends only on registered state (plus reset), never on port_rd.
  assign dev_in_ready = rst && !w_full;
  assign w_push       = dev_in_valid && dev_in_ready;
  assign w_pop        = port_rd && !w_empty;

  assign in_empty  = w_empty;
  assign in_count  = r_wr_ptr - r_rd_ptr;
  assign inputPort = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible between valid pointers.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= dev_in_data;
  end

  // Output register
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_overrun;
  logic              w_overwrite;

  // Overwrite of a word the device has not taken in this same cycle.
  assign w_overwrite = port_wr && r_out_valid && !dev_out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (port_wr) begin
        r_out_data  <= port_wdata;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && dev_out_ready) begin
        r_out_valid <= 1'b0;
      end
      // Set takes priority over clear so a fresh overrun is never masked.
      if (w_overwrite)  r_overrun <= 1'b1;
      else if (ovf_clr) r_overrun <= 1'b0;
    end
  end

  assign outputPort    = r_out_data;
  assign dev_out_valid = r_out_valid;
  assign out_overrun   = r_overrun;

  // Interrupt synchroniser and pending latch
  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic r_int;
  logic w_edge;

  assign w_edge = r_sync2 && !r_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_int   <= 1'b0;
    end else begin
      r_sync1 <= irq_req;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      // A new edge beats a coincident acknowledge so the request is not lost.
      r_int   <= w_edge || (r_int && !int_ack);
    end
  end

  assign interrupt = r_int;

endmodule

// File: tb/tb_io_port_unit.sv
// tb/tb_io_port_unit.sv - self-checking bench for io_port_unit
module tb_io_port_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] dev_in_data;
  logic        dev_in_valid;
  logic        dev_in_ready;
  logic [15:0] inputPort;
  logic        in_empty;
  logic [2:0]  in_count;
  logic        port_rd;
  logic        port_wr;
  logic [15:0] port_wdata;
  logic [15:0] outputPort;
  logic        dev_out_valid;
  logic        dev_out_ready;
  logic        out_overrun;
  logic        ovf_clr;
  logic        irq_req;
  logic        interrupt;
  logic        int_ack;

  int n_chk  = 0;
  int n_fail = 0;

  io_port_unit #(.DATA_W(16), .IN_DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .dev_in_data   (dev_in_data),
    .dev_in_valid  (dev_in_valid),
    .dev_in_ready  (dev_in_ready),
    .inputPort     (inputPort),
    .in_empty      (in_empty),
    .in_count      (in_count),
    .port_rd       (port_rd),
    .port_wr       (port_wr),
    .port_wdata    (port_wdata),
    .outputPort    (outputPort),
    .dev_out_valid (dev_out_valid),
    .dev_out_ready (dev_out_ready),
    .out_overrun   (out_overrun),
    .ovf_clr       (ovf_clr),
    .irq_req       (irq_req),
    .interrupt     (interrupt),
    .int_ack       (int_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    int vin; int din; int rd; int wr; int wd; int ordy; int clr; int irq; int ack;
    int e_rdy; int e_inp; int e_emp; int e_cnt; int e_out; int e_ov; int e_ovr; int e_int;
  } vec_t;

  localparam int NV = 42;
  vec_t vecs [NV];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    dev_in_valid  = 1'b0;
    dev_in_data   = 16'h0;
    port_rd       = 1'b0;
    port_wr       = 1'b0;
    port_wdata    = 16'h0;
    dev_out_ready = 1'b0;
    ovf_clr       = 1'b0;
    irq_req       = 1'b0;
    int_ack       = 1'b0;
  endtask

  task automatic check_all(input string tag, input int rdy, input int inp, input int emp,
                           input int cnt, input int outp, input int ov, input int ovr,
                           input int intr);
    chk({tag, "_dev_in_ready"},  int'(dev_in_ready),  rdy);
    chk({tag, "_inputPort"},     int'(inputPort),     inp);
    chk({tag, "_in_empty"},      int'(in_empty),      emp);
    chk({tag, "_in_count"},      int'(in_count),      cnt);
    chk({tag, "_outputPort"},    int'(outputPort),    outp);
    chk({tag, "_dev_out_valid"}, int'(dev_out_valid), ov);
    chk({tag, "_out_overrun"},   int'(out_overrun),   ovr);
    chk({tag, "_interrupt"},     int'(interrupt),     intr);
  endtask

  initial begin
    int exp_q[$];
    int exp_head;

    // vin din rd wr wd ordy clr irq ack | rdy inp emp cnt out ov ovr int
    // Fill, full-with-pop, drain, empty corner cases
    vecs[0]  = '{1, 'h1111, 0, 0, 0, 0, 0, 0, 0,  1, 'h1111, 0, 1, 0, 0, 0, 0};
    vecs[1]  = '{1, 'h2222, 0, 0, 0, 0, 0, 0, 0,  1, 'h1111, 0, 2, 0, 0, 0, 0};
    vecs[2]  = '{1, 'h3333, 0, 0, 0, 0, 0, 0, 0,  1, 'h1111, 0, 3, 0, 0, 0, 0};
    vecs[3]  = '{1, 'h4444, 0, 0, 0, 0, 0, 0, 0,  0, 'h1111, 0, 4, 0, 0, 0, 0};
    vecs[4]  = '{1, 'h5555, 1, 0, 0, 0, 0, 0, 0,  1, 'h2222, 0, 3, 0, 0, 0, 0};
    vecs[5]  = '{1, 'h5555, 0, 0, 0, 0, 0, 0, 0,  0, 'h2222, 0, 4, 0, 0, 0, 0};
    vecs[6]  = '{0, 0,      1, 0, 0, 0, 0, 0, 0,  1, 'h3333, 0, 3, 0, 0, 0, 0};
    vecs[7]  = '{0, 0,      1, 0, 0, 0, 0, 0, 0,  1, 'h4444, 0, 2, 0, 0, 0, 0};
    vecs[8]  = '{0, 0,      1, 0, 0, 0, 0, 0, 0,  1, 'h5555, 0, 1, 0, 0, 0, 0};
    vecs[9]  = '{0, 0,      1, 0, 0, 0, 0, 0, 0,  1, 0,      1, 0, 0, 0, 0, 0};
    vecs[10] = '{0, 0,      1, 0, 0, 0, 0, 0, 0,  1, 0,      1, 0, 0, 0, 0, 0};
    vecs[11] = '{1, 'hAAAA, 1, 0, 0, 0, 0, 0, 0,  1, 'hAAAA, 0, 1, 0, 0, 0, 0};
    vecs[12] = '{1, 'hBBBB, 1, 0, 0, 0, 0, 0, 0,  1, 'hBBBB, 0, 1, 0, 0, 0, 0};
    vecs[13] = '{0, 0,      1, 0, 0, 0, 0, 0, 0,  1, 0,      1, 0, 0, 0, 0, 0};
    // Output handshake and overrun
    vecs[14] = '{0, 0, 0, 1, 'hABCD, 0, 0, 0, 0,  1, 0, 1, 0, 'hABCD, 1, 0, 0};
    vecs[15] = '{0, 0, 0, 1, 'h1234, 0, 0, 0, 0,  1, 0, 1, 0, 'h1234, 1, 1, 0};
    vecs[16] = '{0, 0, 0, 0, 0,      0, 1, 0, 0,  1, 0, 1, 0, 'h1234, 1, 0, 0};
    vecs[17] = '{0, 0, 0, 0, 0,      1, 0, 0, 0,  1, 0, 1, 0, 'h1234, 0, 0, 0};
    vecs[18] = '{0, 0, 0, 1, 'h5678, 0, 0, 0, 0,  1, 0, 1, 0, 'h5678, 1, 0, 0};
    vecs[19] = '{0, 0, 0, 1, 'h9ABC, 1, 0, 0, 0,  1, 0, 1, 0, 'h9ABC, 1, 0, 0};
    vecs[20] = '{0, 0, 0, 1, 'h1111, 0, 1, 0, 0,  1, 0, 1, 0, 'h1111, 1, 1, 0};
    vecs[21] = '{0, 0, 0, 0, 0,      1, 1, 0, 0,  1, 0, 1, 0, 'h1111, 0, 0, 0};
    // Interrupt: held level, ack, re-arm, edge coincident with ack
    vecs[22] = '{0, 0, 0, 0, 0, 0, 0, 1, 0,  1, 0, 1, 0, 'h1111, 0, 0, 0};
    vecs[23] = '{0, 0, 0, 0, 0, 0, 0, 1, 0,  1, 0, 1, 0, 'h1111, 0, 0, 0};
    vecs[24] = '{0, 0, 0, 0, 0, 0, 0, 1, 0,  1, 0, 1, 0, 'h1111, 0, 0, 1};
    vecs[25] = '{0, 0, 0, 0, 0, 0, 0, 1, 0,  1, 0, 1, 0, 'h1111, 0, 0, 1};
    vecs[26] = '{0, 0, 0, 0, 0, 0, 0, 1, 0,  1, 0, 1, 0, 'h1111, 0, 0, 1};
    vecs[27] = '{0, 0, 0, 0, 0, 0, 0, 1, 1,  1, 0, 1, 0, 'h1111, 0, 0, 0};
    vecs[28] = '{0, 0, 0, 0, 0, 0, 0, 1, 0,  1, 0, 1, 0, 'h1111, 0, 0, 0};
    vecs[29] = '{0, 0, 0, 0, 0, 0, 0, 1, 0,  1, 0, 1, 0, 'h1111, 0, 0, 0};
    vecs[30] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 'h1111, 0, 0, 0};
    vecs[31] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 'h1111, 0, 0, 0};
    vecs[32] = '{0, 0, 0, 0, 0, 0, 0, 1, 0,  1, 0, 1, 0, 'h1111, 0, 0, 0};
    vecs[33] = '{0, 0, 0, 0, 0, 0, 0, 1, 0,  1, 0, 1, 0, 'h1111, 0, 0, 0};
    vecs[34] = '{0, 0, 0, 0, 0, 0, 0, 1, 0,  1, 0, 1, 0, 'h1111, 0, 0, 1};
    vecs[35] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 'h1111, 0, 0, 1};
    vecs[36] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 'h1111, 0, 0, 1};
    vecs[37] = '{0, 0, 0, 0, 0, 0, 0, 1, 0,  1, 0, 1, 0, 'h1111, 0, 0, 1};
    vecs[38] = '{0, 0, 0, 0, 0, 0, 0, 1, 0,  1, 0, 1, 0, 'h1111, 0, 0, 1};
    vecs[39] = '{0, 0, 0, 0, 0, 0, 0, 1, 1,  1, 0, 1, 0, 'h1111, 0, 0, 1};
    vecs[40] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 'h1111, 0, 0, 1};
    vecs[41] = '{0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 1, 0, 'h1111, 0, 0, 0};

    // Reset state
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 0, 1, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("release_dev_in_ready", int'(dev_in_ready), 1);

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      dev_in_valid  = vecs[i].vin[0];
      dev_in_data   = 16'(vecs[i].din);
      port_rd       = vecs[i].rd[0];
      port_wr       = vecs[i].wr[0];
      port_wdata    = 16'(vecs[i].wd);
      dev_out_ready = vecs[i].ordy[0];
      ovf_clr       = vecs[i].clr[0];
      irq_req       = vecs[i].irq[0];
      int_ack       = vecs[i].ack[0];
      @(posedge clk);
      #1;
      check_all($sformatf("v%0d", i), vecs[i].e_rdy, vecs[i].e_inp, vecs[i].e_emp,
                vecs[i].e_cnt, vecs[i].e_out, vecs[i].e_ov, vecs[i].e_ovr, vecs[i].e_int);
    end
    idle_inputs();

    // Wrap-around: push 0, then 9 cycles of simultaneous push/pop, then a final pop
    exp_q.delete();
    for (int i = 0; i <= 10; i++) begin
      dev_in_valid = (i <= 9);
      dev_in_data  = 16'(i);
      port_rd      = (i > 0);
      @(posedge clk);
      #1;
      if (i > 0) void'(exp_q.pop_front());
      if (i <= 9) exp_q.push_back(i);
      exp_head = (exp_q.size() > 0) ? exp_q[0] : 0;
      chk($sformatf("wrap%0d_inputPort", i), int'(inputPort), exp_head);
      chk($sformatf("wrap%0d_in_count", i), int'(in_count), exp_q.size());
      if (in_count > 3'd4) chk($sformatf("wrap%0d_count_le4", i), int'(in_count), 4);
    end
    idle_inputs();
    chk("wrap_end_empty", int'(in_empty), 1);

    // Async reset mid-traffic: 2 words queued, output word pending, interrupt pending
    dev_in_valid = 1'b1;
    dev_in_data  = 16'hC0DE;
    @(posedge clk);
    #1;
    dev_in_data  = 16'hBEEF;
    port_wr      = 1'b1;
    port_wdata   = 16'h7777;
    irq_req      = 1'b1;
    @(posedge clk);
    #1;
    idle_inputs();
    irq_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all("pre_rst", 1, 'hC0DE, 0, 2, 'h7777, 1, 0, 1);
    #2;
    rst = 1'b0;
    #1;
    check_all("async_rst", 0, 0, 1, 0, 0, 0, 0, 0);
    #3;
    rst = 1'b1;
    irq_req = 1'b0;
    #1;
    chk("post_rst_dev_in_ready", int'(dev_in_ready), 1);
    chk("post_rst_in_empty", int'(in_empty), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/io_port_unit.md
# io_port_unit

Peripheral I/O stage between the pipelined processor core and external devices. It buffers incoming device words in a small FIFO that drives the core's `inputPort`, and registers words the core writes through its OUT path into a held `outputPort` with a valid/ready handshake. It also synchronises an asynchronous external interrupt request into a level `interrupt` that stays asserted until the core acknowledges it.

## Interface

Parameters:
- `DATA_W`, 16: port data width.
- `IN_DEPTH`, 4: input FIFO depth. Must be a power of 2 and at least 2.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset. Asynchronous, active-low; 0 = reset.
- `dev_in_data`, input, DATA_W: word from the external device.
- `dev_in_valid`, input, 1: device offers `dev_in_data`.
- `dev_in_ready`, output, 1: FIFO can accept a word. Equals `!full`; forced to 0 while `rst`=0.
- `inputPort`, output, DATA_W: FIFO head word to the core; 0 when the FIFO is empty.
- `in_empty`, output, 1: FIFO empty.
- `in_count`, output, log2(IN_DEPTH)+1: FIFO occupancy.
- `port_rd`, input, 1: core IN-instruction pop strobe.
- `port_wr`, input, 1: core OUT write strobe (from writeback).
- `port_wdata`, input, DATA_W: OUT data.
- `outputPort`, output, DATA_W: last word written by the core.
- `dev_out_valid`, output, 1: `outputPort` holds a word the device has not yet taken.
- `dev_out_ready`, input, 1: device accepts `outputPort`.
- `out_overrun`, output, 1: sticky flag; an unaccepted word was overwritten.
- `ovf_clr`, input, 1: clears `out_overrun`.
- `irq_req`, input, 1: asynchronous external interrupt request.
- `interrupt`, output, 1: pending interrupt to the core.
- `int_ack`, input, 1: core acknowledges the interrupt.

## Operation

Reset (`rst`=0): pointers, count, `outputPort`, `dev_out_valid`, `out_overrun`, the sync flops, the edge register and `interrupt` all go to 0. `in_empty`=1. `inputPort`=0. `dev_in_ready`=0.

Input FIFO:
- Pointers are log2(IN_DEPTH)+1 bits wide and wrap naturally.
  - full = the pointers differ only in the MSB.
  - empty = the pointers are equal.
- Push happens when `dev_in_valid` && `dev_in_ready`.
- Pop happens when `port_rd` && !`in_empty`.
- `port_rd` while empty is ignored; no state change.
- Push and pop in the same cycle with the FIFO not empty and not full: both occur, and the count is unchanged.
- Full: `dev_in_ready`=0 even if `port_rd`=1 in the same cycle. There is no combinational ready path from `port_rd`.
- Empty: an arriving push is accepted, and a simultaneous `port_rd` is ignored.
- `inputPort` is a combinational read of storage[rd_ptr]. It is masked to 0 when empty.

Output register:
- `port_wr`=1 loads `port_wdata` into `outputPort` and sets `dev_out_valid`=1.
- `dev_out_valid` && `dev_out_ready` with no `port_wr`: `dev_out_valid` clears. `outputPort` keeps its value.
- `port_wr` in the same cycle as a completed handshake: the new word loads, `dev_out_valid` stays 1, and no overrun is flagged.
- `port_wr` while `dev_out_valid`=1 and `dev_out_ready`=0: the new word overwrites (latest wins) and `out_overrun` is set to 1.
- `ovf_clr` clears `out_overrun`. If a new overrun occurs in the same cycle, the set wins.

Interrupt:
- `irq_req` passes through a two-flop synchroniser, s1 then s2.
- A register `prev` holds the previous s2.
- edge = s2 && !`prev`.
- Pending state (`interrupt`):
  - edge sets it.
  - `int_ack` clears it.
  - edge and `int_ack` in the same cycle: it stays 1, so the new request is not lost.
- A level held high produces exactly one request.

## Timing

- Push accepted at edge N: `inputPort`/`in_empty` reflect the word after edge N. Latency is 1 cycle.
- Pop at edge N: the next head is visible after edge N.
- `port_wr` at edge N: `outputPort` and `dev_out_valid` update after edge N.
- `irq_req` rises before edge 1: s1=1 after edge 1, s2=1 after edge 2, and `interrupt`=1 after edge 3.
- `int_ack` at edge N: `interrupt`=0 after edge N.
- Reset asserted mid-operation: all state clears immediately, without waiting for a clock edge. FIFO contents are discarded, and a pending output word or interrupt is lost.

## Test plan

- **Fill and drain:** reset, then push 0x1111, 0x2222, 0x3333, 0x4444.
  - Required: `dev_in_ready`=0 and `in_count`=4.
  - Then issue 4 pops. Required: `inputPort` shows the words in order, and ends at 0 with `in_empty`=1.
- **Full with simultaneous pop:** FIFO full, `dev_in_valid`=1 and `port_rd`=1 in the same cycle.
  - Required: only the pop occurs and `in_count`=3.
  - Next cycle: the push is accepted and `in_count`=4.
- **Wrap-around:** 10 interleaved push/pop pairs with values 0x0000 through 0x0009.
  - Required: the values are read in order, no entry is lost, and `in_count` never exceeds 4.
- **Output handshake and overrun:**
  - `port_wr` 0xABCD with `dev_out_ready`=0. Required: `dev_out_valid`=1.
  - `port_wr` 0x1234 next. Required: `outputPort`=0x1234 and `out_overrun`=1.
  - `ovf_clr`, then `dev_out_ready`=1. Required: `out_overrun`=0 and `dev_out_valid`=0.
  - `port_wr` coincident with a handshake. Required: `dev_out_valid` stays 1 and no overrun.
- **Interrupt:**
  - `irq_req` held high. Required: `interrupt`=1 after the 3rd edge, with only one request produced.
  - `int_ack`. Required: `interrupt`=0.
  - New rising edge coincident with `int_ack`. Required: `interrupt` stays 1.
- **Async reset mid-traffic:** `rst`=0 between clock edges while the FIFO holds 2 words and `dev_out_valid`=1.
  - Required: all outputs reach their reset values immediately.
  - After release: `dev_in_ready`=1.
